// File: rtl/alu_share_arb_pkg.sv
// Shared types and opcodes for the ALU sharing arbiter.
// Opcode values match the core's ALU encoding.
package alu_share_arb_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SLL  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_SLT  = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  function automatic logic is_zero(logic [31:0] v);
    return v == 32'd0;
  endfunction

endpackage

// File: rtl/alu.sv
// Core ALU: 32-bit combinational datapath.
// f is the zero flag of the result.
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] c,
  output logic        f
);

  logic [4:0] sh;

  assign sh = b[4:0];

  always_comb begin
    c = 32'd0;
    unique case (op)
      ALU_OP_ADD:  c = a + b;
      ALU_OP_SUB:  c = a - b;
      ALU_OP_AND:  c = a & b;
      ALU_OP_OR:   c = a | b;
      ALU_OP_XOR:  c = a ^ b;
      ALU_OP_SLL:  c = a << sh;
      ALU_OP_SRL:  c = a >> sh;
      ALU_OP_SRA:  c = $signed(a) >>> sh;
      ALU_OP_SLT:  c = {31'd0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: c = {31'd0, a < b};
      default:     c = 32'd0;
    endcase
  end

  assign f = is_zero(c);

endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Round-robin picker: first requester after last,
// searching upward with wrap. Purely combinational.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(last) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters, one op in flight,
// round-robin grant, registered operands and result.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    rsp_c,
  output logic            rsp_f,
  output logic            busy
);

  localparam int IW = $clog2(NREQ);

  if (W != 32) begin : g_bad_width
    $error("alu_share_arb: W must be 32");
  end

  arb_state_t      state;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] rsp_vec;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [3:0]      op_q;
  logic [W-1:0]    alu_c;
  logic            alu_f;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req_valid),
    .last (last_gnt),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .c  (alu_c),
    .f  (alu_f)
  );

  // Offers are masked during reset so nothing looks accepted.
  assign req_ready = (state == ARB_IDLE && !rst)
                   ? pick_gnt : '0;

  always_comb begin
    rsp_vec = '0;
    if (state == ARB_RESP) rsp_vec[gnt_q] = 1'b1;
  end

  assign rsp_valid = rsp_vec;
  assign busy      = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last_gnt <= IW'(NREQ - 1);
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rsp_c    <= '0;
      rsp_f    <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            a_q   <= req_a[pick_idx*W +: W];
            b_q   <= req_b[pick_idx*W +: W];
            op_q  <= req_op[pick_idx*4 +: 4];
            gnt_q <= pick_idx;
            state <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          rsp_c <= alu_c;
          rsp_f <= alu_f;
          state <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_ready[gnt_q]) begin
            last_gnt <= gnt_q;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level model checked
// every cycle, plus directed literal checks.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*4-1:0]  req_op;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [W-1:0]    rsp_c;
  logic            rsp_f;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_f     (rsp_f),
    .busy      (busy)
  );

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUB:  return a - b;
      ALU_OP_AND:  return a & b;
      ALU_OP_OR:   return a | b;
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_SLL:  return a << sh;
      ALU_OP_SRL:  return a >> sh;
      ALU_OP_SRA:  return $signed(a) >>> sh;
      ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic int rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Transaction model: an accepted op is silent for one cycle,
  // then responds until its own requester takes it.
  bit          known    = 1'b0;
  bit          inflight = 1'b0;
  int          age      = 0;
  int          who      = 0;
  int          last     = N - 1;
  logic [31:0] res      = '0;
  logic [31:0] c_m      = '0;
  logic        f_m      = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_vld;
    int w;
    if (known) begin
      e_rdy = '0;
      e_vld = '0;
      if (!inflight) begin
        w = rr(req_valid, last);
        if (w >= 0 && !rst) e_rdy[w] = 1'b1;
      end else if (age >= 1) begin
        e_vld[who] = 1'b1;
      end
      chk("m_req_ready", 64'(req_ready), 64'(e_rdy));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(e_vld));
      chk("m_busy", 64'(busy), 64'(inflight));
      chk("m_rsp_c", 64'(rsp_c), 64'(c_m));
      chk("m_rsp_f", 64'(rsp_f), 64'(f_m));
    end
    if (rst) begin
      known    = 1'b1;
      inflight = 1'b0;
      last     = N - 1;
      c_m      = '0;
      f_m      = 1'b0;
    end else if (known) begin
      if (!inflight) begin
        w = rr(req_valid, last);
        if (w >= 0) begin
          inflight = 1'b1;
          age      = 0;
          who      = w;
          res = ref_alu(req_op[w*4 +: 4], req_a[w*W +: W],
                        req_b[w*W +: W]);
        end
      end else if (age == 0) begin
        age = 1;
        c_m = res;
        f_m = (res == 32'd0);
      end else if (rsp_ready[who]) begin
        inflight = 1'b0;
        last     = who;
      end
    end
  end

  task automatic set_req(int i, logic [3:0] op,
                         logic [31:0] a, logic [31:0] b);
    req_op[i*4 +: 4] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(string name, output int idx);
    idx = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        idx = req_ready[1] ? 1 : 0;
        break;
      end
    end
    if (idx < 0) timeout(name);
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int idx;
    logic [31:0] held;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    set_req(0, ALU_OP_ADD, 32'd1, 32'd2);
    set_req(1, ALU_OP_ADD, 32'd3, 32'd4);

    // Reset held two cycles with all requests valid
    tick();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_c", 64'(rsp_c), 64'd0);
      tick();
    end
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // Single OR op: latency 2
    set_req(0, ALU_OP_OR, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b01;
    wait_ready("t2_accept", idx);
    chk("t2_grant", 64'(idx), 64'd0);
    tick();
    req_valid = '0;
    set_req(0, ALU_OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t2_t1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t2_valid", 64'(rsp_valid), 64'b01);
    chk("t2_c", 64'(rsp_c), 64'h0000_00FF);
    chk("t2_f", 64'(rsp_f), 64'd0);
    tick();
    wait_idle("t2_idle");

    // Contention from reset, with backpressure on the third op
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, ALU_OP_SUB, 32'd10, 32'd3);
    set_req(1, ALU_OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_ready("t3_accept", idx);
      chk("t3_grant", 64'(idx), 64'(g % 2));
      tick();
      if (g == 2) begin
        rsp_ready = 2'b00;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (s == 0) held = rsp_c;
          chk("t4_valid", 64'(rsp_valid), 64'b01);
          chk("t4_c", 64'(rsp_c), 64'd7);
          chk("t4_stable", 64'(rsp_c), 64'(held));
          chk("t4_ready", 64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("t4_wrong_rdy", 64'(rsp_valid), 64'b01);
        tick();
        rsp_ready = 2'b11;
      end
    end
    req_valid = '0;
    wait_idle("t3_idle");

    // Shift amount uses only B[4:0]
    set_req(0, ALU_OP_SLL, 32'h1, 32'h24);
    req_valid = 2'b01;
    wait_ready("t5_accept", idx);
    chk("t5_grant", 64'(idx), 64'd0);
    tick();
    req_valid = '0;
    set_req(0, ALU_OP_SLL, 32'hFFFF, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_c", 64'(rsp_c), 64'h10);
    chk("t5_valid", 64'(rsp_valid), 64'b01);
    tick();
    wait_idle("t5_idle");

    // Abort in EXEC, then reissue
    set_req(1, ALU_OP_ADD, 32'd5, 32'd6);
    req_valid = 2'b10;
    wait_ready("t6_accept", idx);
    chk("t6_grant", 64'(idx), 64'd1);
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_valid", 64'(rsp_valid), 64'd0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    req_valid = 2'b10;
    wait_ready("t6_reissue", idx);
    chk("t6_regrant", 64'(idx), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rvalid", 64'(rsp_valid), 64'b10);
    chk("t6_c", 64'(rsp_c), 64'd11);
    tick();
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
